// File: rtl/jpeg_decoder_output_writer.sv
// Streams decoded JPEG words from the output FIFO to memory as AXI-4 INCR write bursts.
// Optional macro JPEG_DEC_OUTPUT_WRITER_BSWAP_EN byte-reverses each written word.
module jpeg_decoder_output_writer #(
  parameter int BURST_BEATS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [21:0] length_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_valid_i,
  input  logic [10:0] fifo_level_i,
  output logic        fifo_pop_o,
  output logic        axi_awvalid_o,
  input  logic        axi_awready_i,
  output logic [31:0] axi_awaddr_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  output logic [3:0]  axi_awid_o,
  output logic        axi_wvalid_o,
  input  logic        axi_wready_i,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_bready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [21:0] remain_q, remain_d;
  logic [4:0]  beat_q, beat_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [4:0]  beats;
  logic        last_beat;
  logic        w_fire;

  // Burst length is fixed for the whole burst because remain_q only moves in RESP.
  assign beats     = (remain_q >= 22'(BURST_BEATS)) ? 5'(BURST_BEATS) : remain_q[4:0];
  assign last_beat = (beat_q == (beats - 5'd1));

  assign axi_awvalid_o = (state_q == S_ADDR);
  assign axi_awaddr_o  = axi_awvalid_o ? addr_q : 32'd0;
  assign axi_awlen_o   = axi_awvalid_o ? {3'd0, beats - 5'd1} : 8'd0;
  assign axi_awburst_o = axi_awvalid_o ? 2'b01 : 2'b00;
  assign axi_awid_o    = 4'd0;

  assign axi_wvalid_o  = (state_q == S_DATA) && fifo_valid_i;
  assign axi_wstrb_o   = (state_q == S_DATA) ? 4'hF : 4'h0;
  assign axi_wlast_o   = axi_wvalid_o && last_beat;
  assign w_fire        = axi_wvalid_o && axi_wready_i;
  assign fifo_pop_o    = w_fire;

`ifdef JPEG_DEC_OUTPUT_WRITER_BSWAP_EN
  assign axi_wdata_o = {fifo_data_i[7:0], fifo_data_i[15:8], fifo_data_i[23:16], fifo_data_i[31:24]};
`else
  assign axi_wdata_o = fifo_data_i;
`endif

  assign axi_bready_o = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign error_o      = error_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      remain_q <= 22'd0;
      beat_q   <= 5'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i != 22'd0) begin
            addr_d   = base_addr_i & 32'hFFFF_FFC0;
            remain_d = length_i;
            beat_d   = 5'd0;
            error_d  = 1'b0;
            state_d  = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Only request the bus once the whole burst is buffered so W never starves for long.
        if (fifo_level_i >= 11'(beats)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (axi_awready_i) begin
          beat_d  = 5'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          if (last_beat) begin
            beat_d  = 5'd0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      S_RESP: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i != 2'b00) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d   = addr_q + {25'd0, beats, 2'b00};
            remain_d = remain_q - {17'd0, beats};
            if (remain_d == 22'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_jpeg_decoder_output_writer.sv
// Scoreboard bench for jpeg_decoder_output_writer: stimulus queues expected AW/W traffic,
// a negedge monitor pops and compares every handshake.
module tb_jpeg_decoder_output_writer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [21:0] length_i;
  logic [31:0] fifo_data_i;
  logic        fifo_valid_i;
  logic [10:0] fifo_level_i;
  logic        fifo_pop_o;
  logic        axi_awvalid_o, axi_awready_i;
  logic [31:0] axi_awaddr_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic [3:0]  axi_awid_o;
  logic        axi_wvalid_o, axi_wready_i;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wlast_o;
  logic        axi_bvalid_i;
  logic [1:0]  axi_bresp_i;
  logic        axi_bready_o;
  logic        busy_o, done_o, error_o;

  jpeg_decoder_output_writer #(.BURST_BEATS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .length_i(length_i), .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i),
    .fifo_level_i(fifo_level_i), .fifo_pop_o(fifo_pop_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awid_o(axi_awid_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
    .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bready_o(axi_bready_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] fq[$];
  logic [1:0]  bresp_q[$];
  aw_t         ea;
  w_t          ew;

  int checks = 0, fails = 0;
  int aw_cnt = 0, w_cnt = 0, pop_cnt = 0, done_cnt = 0, pops_done = 0;
  bit saw_bready = 0, b_hs = 0, gap = 0, wr_toggle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef JPEG_DEC_OUTPUT_WRITER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Monitor: handshakes observed here complete on the following rising edge.
  always @(negedge clk_i) begin
    if (axi_awvalid_o && axi_awready_i) begin
      aw_cnt++;
      if (exp_aw.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
      else begin
        ea = exp_aw.pop_front();
        chk("awaddr", axi_awaddr_o, ea.addr);
        chk("awlen", {24'd0, axi_awlen_o}, {24'd0, ea.len});
        chk("awburst", {30'd0, axi_awburst_o}, 32'd1);
      end
    end
    if (axi_wvalid_o && axi_wready_i) begin
      w_cnt++;
      chk("pop_on_beat", {31'd0, fifo_pop_o}, 32'd1);
      if (exp_w.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
      else begin
        ew = exp_w.pop_front();
        chk("wdata", axi_wdata_o, ew.data);
        chk("wlast", {31'd0, axi_wlast_o}, {31'd0, ew.last});
        chk("wstrb", {28'd0, axi_wstrb_o}, 32'hF);
      end
    end
    if (fifo_pop_o) pop_cnt++;
    if (done_o) done_cnt++;
    saw_bready = axi_bready_o;
    b_hs       = axi_bvalid_i && axi_bready_o;
  end

  // Responder: FIFO model, AXI slave ready/response generation.
  initial begin
    axi_awready_i = 1'b1;
    axi_wready_i  = 1'b1;
    axi_bvalid_i  = 1'b0;
    axi_bresp_i   = 2'b00;
    fifo_valid_i  = 1'b0;
    fifo_data_i   = 32'd0;
    fifo_level_i  = 11'd0;
    forever begin
      @(posedge clk_i); #2;
      while (pops_done < pop_cnt) begin
        if (fq.size() > 0) void'(fq.pop_front());
        pops_done++;
      end
      if (rst_i || b_hs) axi_bvalid_i = 1'b0;
      else if (saw_bready && !axi_bvalid_i) begin
        axi_bvalid_i = 1'b1;
        axi_bresp_i  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
      end
      axi_wready_i = wr_toggle ? ~axi_wready_i : 1'b1;
      fifo_valid_i = (fq.size() > 0) && !gap;
      fifo_data_i  = (fq.size() > 0) ? fq[0] : 32'd0;
      fifo_level_i = 11'(fq.size());
    end
  end

  task automatic fill(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) fq.push_back(seed + 32'(i));
  endtask

  task automatic expect_burst(input logic [31:0] addr, input int beats, input logic [31:0] seed);
    aw_t a;
    w_t  w;
    a.addr = addr;
    a.len  = 8'(beats - 1);
    exp_aw.push_back(a);
    for (int i = 0; i < beats; i++) begin
      w.data = xf(seed + 32'(i));
      w.last = (i == beats - 1);
      exp_w.push_back(w);
    end
  endtask

  task automatic go(input logic [31:0] base, input logic [21:0] len);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = base; length_i = len;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (done_cnt < target) chk({name, "_timeout"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (w_cnt < target && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (w_cnt < target) chk({name, "_beat_timeout"}, 32'(w_cnt), 32'(target));
  endtask

  task automatic finish_test(input string name, input int aw0, input int d0, input int w0,
                             input int p0, input int aw_exp, input logic err_exp);
    repeat (4) @(negedge clk_i);
    chk({name, "_aw_count"}, 32'(aw_cnt - aw0), 32'(aw_exp));
    chk({name, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
    chk({name, "_w_left"}, 32'(exp_w.size()), 32'd0);
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_pops_eq_beats"}, 32'(pop_cnt - p0), 32'(w_cnt - w0));
    chk({name, "_error"}, {31'd0, error_o}, {31'd0, err_exp});
    chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  int aw0, d0, w0, p0, f0;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 32'd0; length_i = 22'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_awvalid", {31'd0, axi_awvalid_o}, 32'd0);
    chk("rst_wvalid", {31'd0, axi_wvalid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_awaddr", axi_awaddr_o, 32'd0);
    chk("rst_awlen", {24'd0, axi_awlen_o}, 32'd0);
    chk("rst_bready", {31'd0, axi_bready_o}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Two full bursts; a second start while busy must be ignored.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    fill(32, 32'h1100_0000);
    expect_burst(32'h0000_1000, 16, 32'h1100_0000);
    expect_burst(32'h0000_1040, 16, 32'h1100_0010);
    go(32'h0000_1000, 22'd32);
    wait_beats(w0 + 3, "t32");
    go(32'h0000_9000, 22'd5);
    wait_done(d0 + 1, "t32");
    finish_test("t32", aw0, d0, w0, p0, 2, 1'b0);

    // Short tail burst.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    fill(20, 32'h2200_0000);
    expect_burst(32'h0000_2000, 16, 32'h2200_0000);
    expect_burst(32'h0000_2040, 4, 32'h2200_0010);
    go(32'h0000_2000, 22'd20);
    wait_done(d0 + 1, "t20");
    finish_test("t20", aw0, d0, w0, p0, 2, 1'b0);

    // FIFO level gating.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    fill(10, 32'h3300_0000);
    expect_burst(32'h0000_3000, 16, 32'h3300_0000);
    go(32'h0000_3000, 22'd16);
    repeat (30) @(negedge clk_i);
    chk("lvl_aw_held", 32'(aw_cnt - aw0), 32'd0);
    chk("lvl_busy", {31'd0, busy_o}, 32'd1);
    fill(6, 32'h3300_000A);
    wait_done(d0 + 1, "lvl");
    finish_test("lvl", aw0, d0, w0, p0, 1, 1'b0);

    // Error response aborts; unaligned base bits dropped.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    fill(48, 32'h4400_0000);
    bresp_q.push_back(2'b10);
    expect_burst(32'h0000_4000, 16, 32'h4400_0000);
    go(32'h0000_4025, 22'd48);
    wait_done(d0 + 1, "err");
    finish_test("err", aw0, d0, w0, p0, 1, 1'b1);
    repeat (20) @(negedge clk_i);
    chk("err_no_more_aw", 32'(aw_cnt - aw0), 32'd1);
    fq.delete();

    // Throttled W channel plus a FIFO gap mid-burst.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    wr_toggle = 1'b1;
    fill(16, 32'h5500_0000);
    expect_burst(32'h0000_5000, 16, 32'h5500_0000);
    go(32'h0000_5000, 22'd16);
    wait_beats(w0 + 5, "thr");
    gap = 1'b1;
    repeat (4) @(posedge clk_i);
    gap = 1'b0;
    wait_done(d0 + 1, "thr");
    wr_toggle = 1'b0;
    finish_test("thr", aw0, d0, w0, p0, 1, 1'b0);

    // Zero-length start.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    go(32'h0000_7000, 22'd0);
    wait_done(d0 + 1, "len0");
    finish_test("len0", aw0, d0, w0, p0, 0, 1'b0);

    // Address wrap at 2^32.
    aw0 = aw_cnt; d0 = done_cnt; w0 = w_cnt; p0 = pop_cnt;
    fill(32, 32'h8800_0000);
    expect_burst(32'hFFFF_FFC0, 16, 32'h8800_0000);
    expect_burst(32'h0000_0000, 16, 32'h8800_0010);
    go(32'hFFFF_FFC0, 22'd32);
    wait_done(d0 + 1, "wrap");
    finish_test("wrap", aw0, d0, w0, p0, 2, 1'b0);

    // Reset in the middle of the data phase.
    w0 = w_cnt;
    fill(16, 32'h6600_0000);
    expect_burst(32'h0000_6000, 16, 32'h6600_0000);
    go(32'h0000_6000, 22'd16);
    wait_beats(w0 + 4, "mrst");
    @(posedge clk_i); #3 rst_i = 1'b1;
    @(negedge clk_i);
    chk("mrst_awvalid", {31'd0, axi_awvalid_o}, 32'd0);
    chk("mrst_wvalid", {31'd0, axi_wvalid_o}, 32'd0);
    chk("mrst_wlast", {31'd0, axi_wlast_o}, 32'd0);
    chk("mrst_pop", {31'd0, fifo_pop_o}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_bready", {31'd0, axi_bready_o}, 32'd0);
    chk("mrst_done", {31'd0, done_o}, 32'd0);
    p0 = pop_cnt; f0 = fq.size();
    repeat (3) @(negedge clk_i);
    chk("mrst_no_pops", 32'(pop_cnt - p0), 32'd0);
    chk("mrst_fifo_kept", 32'(fq.size()), 32'(f0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    exp_w.delete(); exp_aw.delete(); fq.delete();
    repeat (3) @(negedge clk_i);
    chk("mrst_idle", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/jpeg_decoder_output_writer.md
JPEG_DECODER_OUTPUT_WRITER -- requirements
Module: jpeg_decoder_output_writer

Interface
REQ-001 Parameter BURST_BEATS, default 16, meaning the maximum AXI-4 write burst length in 32-bit beats (power of two, 1..16).
REQ-002 One clock; reset is asynchronous and active-high (clk_i, rst_i).
REQ-003 clk_i  in  1  clock; all logic rising-edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 start_i  in  1  single-cycle pulse that starts a transfer (sampled in IDLE only).
REQ-006 base_addr_i  in  32  destination byte address; bits [5:0] are ignored and treated as zero.
REQ-007 length_i  in  22  transfer length in 32-bit words.
REQ-008 fifo_data_i  in  32  head word of the output FIFO.
REQ-009 fifo_valid_i  in  1  head word present.
REQ-010 fifo_level_i  in  11  number of words held in the output FIFO.
REQ-011 fifo_pop_o  out  1  consumes the head word.
REQ-012 axi_awvalid_o/awready_i/awaddr_o[31:0]/awlen_o[7:0]/awburst_o[1:0]/awid_o[3:0]  AXI-4 write-address channel.
REQ-013 axi_wvalid_o/wready_i/wdata_o[31:0]/wstrb_o[3:0]/wlast_o  AXI-4 write-data channel.
REQ-014 axi_bvalid_i/bresp_i[1:0]/bready_o  AXI-4 write-response channel.
REQ-015 busy_o  out  1  transfer in progress; done_o  out  1  single-cycle completion pulse; error_o  out  1  sticky error flag.

Function
REQ-016 States: IDLE, WAIT, ADDR, DATA, RESP.
REQ-017 IDLE + start_i with length_i != 0: latch address and remaining count, clear error_o, go to WAIT; with length_i == 0: pulse done_o next cycle and stay in IDLE.
REQ-018 Burst size beats = min(BURST_BEATS, remaining); WAIT moves to ADDR when fifo_level_i >= beats.
REQ-019 ADDR: axi_awvalid_o = 1, awlen_o = beats-1, awburst_o = 2'b01 (INCR), awid_o = 0; go to DATA on awready_i.
REQ-020 DATA: axi_wvalid_o = fifo_valid_i, wdata_o = fifo_data_i, wstrb_o = 4'hF; fifo_pop_o = axi_wvalid_o & axi_wready_i, combinationally.
REQ-021 wlast_o asserted on the final beat of each burst; a beat counter advances on each accepted beat; after the last accepted beat go to RESP.
REQ-022 RESP: bready_o = 1; on bvalid_i, address advances by beats*4, remaining decreases by beats; go to WAIT if remaining != 0, else IDLE with done_o pulsed for one cycle.
REQ-023 bresp_i != 2'b00: set error_o, abort to IDLE, pulse done_o; no further bursts are issued.
REQ-024 Exactly one burst outstanding; W is never driven before AW is accepted.
REQ-025 Base 64-byte aligned and bursts <= 64 bytes guarantee no 4 KB boundary crossing.
REQ-026 start_i while busy_o = 1 is ignored.
REQ-027 busy_o = 1 in every state except IDLE.
REQ-028 A stall (fifo_valid_i = 0 mid-burst) holds wvalid low without losing beat position.
REQ-029 Address arithmetic wraps modulo 2^32.

Reset
REQ-030 Reset returns the FSM to IDLE and drives all outputs to 0 (awvalid, wvalid, wlast, bready, fifo_pop, busy, done, error, awaddr, awlen).
REQ-031 Reset asserted mid-burst abandons the burst immediately; FIFO contents are not popped further.

Configuration
REQ-032 Macro JPEG_DEC_OUTPUT_WRITER_BSWAP_EN: when defined, wdata_o = byte-reversed fifo_data_i ({[7:0],[15:8],[23:16],[31:24]}); when undefined, wdata_o = fifo_data_i unmodified.

Verification
REQ-033 base 0x1000, length 32, FIFO pre-filled, ready always 1 -> two AW (0x1000, 0x1040, awlen 15), 32 beats, done_o one pulse, error_o 0.
REQ-034 length 20 -> bursts awlen 15 then awlen 3 at base+0x40; wlast on beats 16 and 20.
REQ-035 fifo_level_i stays at 10 with length 16 -> no AW issued until level reaches 16.
REQ-036 bresp 2'b10 on first burst of length 48 -> error_o = 1, done_o pulse, no second AW.
REQ-037 wready toggled every other cycle plus fifo_valid gap mid-burst -> pops equal accepted beats, data order preserved.
REQ-038 length 0 start -> done_o pulses, no AXI activity; rst_i mid-DATA -> all outputs 0 next cycle.
